mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
MEM-stage load/store unit that consumes the EX-stage outputs (aluop, mem_addr, reg2, wd, wreg, wdata) and performs the data-memory access over a req/ack data bus. It produces the registered MEM/WB write-back bundle and raises a stall request while a bus transaction is outstanding. Byte-lane steering, load extension, alignment checking and bus timeout are handled here.

Parameters:
ALUOP_W, 8, width of the aluop bus; op codes come from the shared ALU_OP_* defines.
TIMEOUT, 255, maximum BUSY cycles without ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
aluop_i  in  ALUOP_W  op from EX
mem_addr_i  in  32  effective address from EX
reg2_i  in  32  store data from EX
wd_i  in  5  destination register
wreg_i  in  1  register write enable
wdata_i  in  32  EX result for non-memory ops
dbus_req  out  1  bus request, registered
dbus_we  out  1  1 = store
dbus_addr  out  32  word address {mem_addr[31:2],2'b00}
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-replicated store data
dbus_rdata  in  32  read data, valid when dbus_ack = 1
dbus_ack  in  1  single-cycle transfer completion
wd_o  out  5  MEM/WB destination register
wreg_o  out  1  MEM/WB write enable
wdata_o  out  32  MEM/WB write data
stallreq  out  1  combinational; holds upstream stages
addr_err_o  out  1  one-cycle pulse on a misaligned access
bus_err_o  out  1  one-cycle pulse on a bus timeout
bad_addr_o  out  32  faulting address, held until the next error

Behaviour:
- Reset: state IDLE; every output 0; timeout counter 0. Reset is asynchronous, so reset mid-transaction drops dbus_req immediately and the transaction is abandoned.
- Memory ops are LB, LH, LW, SB, SH, SW. All other aluop values pass through: wd/wreg/wdata are registered next cycle, with no stall.
- Alignment: LH/SH need addr[0]=0; LW/SW need addr[1:0]=0. On a misaligned access in IDLE:
  - no bus access and no stall;
  - next cycle: wreg_o=0, addr_err_o=1 for one cycle, bad_addr_o=mem_addr_i.
- Lanes are little-endian (addr[1:0]=0 maps to bits 7:0).
  - be: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111. Loads drive the same be pattern.
  - Store data: SB = {4{reg2[7:0]}}, SH = {2{reg2[15:0]}}, SW = reg2.
- Load result:
  - LB: sign-extends the selected byte.
  - LH: sign-extends the selected half.
  - LW: the word unchanged.
- FSM IDLE:
  - With an aligned memory op, stallreq=1.
  - At the clock edge: go to BUSY; load dbus_req=1, dbus_we, dbus_addr, dbus_be, dbus_wdata; clear the counter.
  - The MEM/WB bundle is not updated at this edge.
- FSM BUSY:
  - dbus_* outputs are held stable.
  - If dbus_ack=0: stallreq=1 and the counter increments.
  - If dbus_ack=1: stallreq=0. At the edge: dbus_req=0; wd_o=wd_i, wreg_o=wreg_i; wdata_o = extended load data for loads, 0 for stores; return to IDLE.
- Minimum memory-op latency is 2 cycles (ack in the first BUSY cycle).
- Upstream holds all *_i inputs stable while stallreq=1.
- Timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack:
  - stallreq=0 in that cycle;
  - next edge: IDLE, dbus_req=0, wreg_o=0, bus_err_o pulse, bad_addr_o=mem_addr_i.
- An ack that coincides with the timeout cycle counts as success.
- dbus_ack while IDLE is ignored.
- Back-to-back memory ops: IDLE→BUSY→IDLE→BUSY; one IDLE cycle (stalled) between transactions.

Test Plan:
1. ORI result wdata_i=0x0000_1234, wd_i=3, wreg_i=1 -> next cycle wdata_o=0x1234, wd_o=3, wreg_o=1; stallreq never high; dbus_req stays 0.
2. LB, addr=0x1003, ack after 3 BUSY cycles with rdata=0x80FF_1122 -> dbus_be=1000; stallreq high for 4 cycles; wdata_o=0xFFFF_FF80.
3. SH, addr=0x2002, reg2=0xABCD_5678, immediate ack -> dbus_we=1, be=1100, wdata=0x5678_5678; stallreq high 1 cycle; total latency 2.
4. LW, addr=0x3001 -> no dbus_req; addr_err_o pulses once; bad_addr_o=0x3001; wreg_o=0.
5. LW with TIMEOUT=4 and ack never given -> stallreq high for 4 cycles (IDLE cycle plus 3 BUSY cycles) then low in the 4th BUSY cycle; bus_err_o pulses; dbus_req=0; wreg_o=0.
6. rst asserted during BUSY of an SW -> dbus_req=0 and all outputs 0 without a clock edge; after release, a following LH at 0x10 completes normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage load/store unit: drives a req/ack data bus for LB/LH/LW/SB/SH/SW,
// steers byte lanes, sign-extends loads and registers the MEM/WB bundle.
module mem_access #(
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        reg2_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  output logic               dbus_req,
  output logic               dbus_we,
  output logic [31:0]        dbus_addr,
  output logic [3:0]         dbus_be,
  output logic [31:0]        dbus_wdata,
  input  logic [31:0]        dbus_rdata,
  input  logic               dbus_ack,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               stallreq,
  output logic               addr_err_o,
  output logic               bus_err_o,
  output logic [31:0]        bad_addr_o
);

  localparam logic [ALUOP_W-1:0] ALU_OP_LB = ALUOP_W'(8'hE0);
  localparam logic [ALUOP_W-1:0] ALU_OP_LH = ALUOP_W'(8'hE1);
  localparam logic [ALUOP_W-1:0] ALU_OP_LW = ALUOP_W'(8'hE3);
  localparam logic [ALUOP_W-1:0] ALU_OP_SB = ALUOP_W'(8'hE8);
  localparam logic [ALUOP_W-1:0] ALU_OP_SH = ALUOP_W'(8'hE9);
  localparam logic [ALUOP_W-1:0] ALU_OP_SW = ALUOP_W'(8'hEB);
  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_load, is_store, mem_op, misaligned, timeout_hit;
  logic [1:0]        size;
  logic [3:0]        be_c;
  logic [31:0]       st_data_c, ld_data_c;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              start, finish, abort;

  // Op decode, alignment, lane steering
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (aluop_i)
      ALU_OP_LB: begin is_load  = 1'b1; size = 2'd0; end
      ALU_OP_LH: begin is_load  = 1'b1; size = 2'd1; end
      ALU_OP_LW: begin is_load  = 1'b1; size = 2'd2; end
      ALU_OP_SB: begin is_store = 1'b1; size = 2'd0; end
      ALU_OP_SH: begin is_store = 1'b1; size = 2'd1; end
      ALU_OP_SW: begin is_store = 1'b1; size = 2'd2; end
      default: ;
    endcase
    mem_op     = is_load | is_store;
    misaligned = ((size == 2'd1) && mem_addr_i[0]) ||
                 ((size == 2'd2) && (mem_addr_i[1:0] != 2'b00));
    case (size)
      2'd0:    begin be_c = 4'b0001 << mem_addr_i[1:0]; st_data_c = {4{reg2_i[7:0]}}; end
      2'd1:    begin be_c = mem_addr_i[1] ? 4'b1100 : 4'b0011; st_data_c = {2{reg2_i[15:0]}}; end
      default: begin be_c = 4'b1111; st_data_c = reg2_i; end
    endcase
  end

  // Load extraction and sign extension
  always_comb begin
    ld_byte = dbus_rdata[{mem_addr_i[1:0], 3'b000} +: 8];
    ld_half = mem_addr_i[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (size)
      2'd0:    ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_data_c = {{16{ld_half[15]}}, ld_half};
      default: ld_data_c = dbus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && !misaligned) state_nxt = BUSY;
      BUSY:    if (dbus_ack || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall and datapath strobes; an ack in the timeout cycle wins
  always_comb begin
    stallreq = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        start    = mem_op && !misaligned;
        stallreq = start;
      end
      BUSY: begin
        finish   = dbus_ack;
        abort    = !dbus_ack && timeout_hit;
        stallreq = !dbus_ack && !timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_be    <= 4'h0;
      dbus_wdata <= 32'h0;
      wd_o       <= 5'h0;
      wreg_o     <= 1'b0;
      wdata_o    <= 32'h0;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      bad_addr_o <= 32'h0;
      cnt        <= '0;
    end else begin
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          dbus_req   <= 1'b1;
          dbus_we    <= is_store;
          dbus_addr  <= {mem_addr_i[31:2], 2'b00};
          dbus_be    <= be_c;
          dbus_wdata <= st_data_c;
          cnt        <= '0;
        end else if (mem_op) begin
          wd_o       <= wd_i;
          wreg_o     <= 1'b0;
          wdata_o    <= 32'h0;
          addr_err_o <= 1'b1;
          bad_addr_o <= mem_addr_i;
        end else begin
          wd_o    <= wd_i;
          wreg_o  <= wreg_i;
          wdata_o <= wdata_i;
        end
      end else if (finish) begin
        dbus_req <= 1'b0;
        wd_o     <= wd_i;
        wreg_o   <= wreg_i;
        wdata_o  <= is_load ? ld_data_c : 32'h0;
      end else if (abort) begin
        dbus_req   <= 1'b0;
        wreg_o     <= 1'b0;
        bus_err_o  <= 1'b1;
        bad_addr_o <= mem_addr_i;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT=4): pass-through, loads, stores,
// misalignment, bus timeout and asynchronous reset mid-transaction.
module tb_mem_access;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ORI = 8'h0D;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, dbus_rdata;
  logic [4:0]  wd_i;
  logic        wreg_i, dbus_ack;
  logic        dbus_req, dbus_we, wreg_o, stallreq, addr_err_o, bus_err_o;
  logic [31:0] dbus_addr, dbus_wdata, wdata_o, bad_addr_o;
  logic [3:0]  dbus_be;
  logic [4:0]  wd_o;

  int checks = 0;
  int failures = 0;

  // Snapshot of the bus taken in the first BUSY cycle
  logic        snap_req, snap_we;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wdata;
  int          stalls, cycles;

  mem_access #(.ALUOP_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq(stallreq), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o),
    .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; wd_i = wd; wreg_i = wr; wdata_i = wdat;
  endtask

  // Runs one memory op already on the inputs; ack in BUSY cycle ack_at (0 = never).
  task automatic run_mem(input int ack_at, input logic [31:0] rd);
    bit done = 1'b0;
    stalls = 0;
    cycles = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k != 0 && k == ack_at) begin
        dbus_ack = 1'b1;
        dbus_rdata = rd;
      end
      @(negedge clk);
      if (k == 1) begin
        snap_req = dbus_req; snap_we = dbus_we; snap_be = dbus_be;
        snap_addr = dbus_addr; snap_wdata = dbus_wdata;
      end
      cycles++;
      if (stallreq) stalls++;
      else done = 1'b1;
      step();
      dbus_ack = 1'b0;
    end
    if (!done) begin
      failures++;
      $display("FAIL run_mem_bound: stall never released after %0d cycles", cycles);
    end
  endtask

  initial begin
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dbus_req), 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_stall", 32'(stallreq), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1: pass-through op, stray ack while IDLE is ignored
    drive(OP_ORI, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_1234);
    dbus_ack = 1'b1;
    @(negedge clk);
    check("ori_stall", 32'(stallreq), 32'h0);
    step();
    dbus_ack = 1'b0;
    check("ori_wdata", wdata_o, 32'h0000_1234);
    check("ori_wd", 32'(wd_o), 32'd3);
    check("ori_wreg", 32'(wreg_o), 32'h1);
    check("ori_req", 32'(dbus_req), 32'h0);

    // 2: LB at lane 3, ack in 4th BUSY cycle (also the timeout cycle)
    drive(OP_LB, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    run_mem(4, 32'h80FF_1122);
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    check("lb_req_busy", 32'(snap_req), 32'h1);
    check("lb_we", 32'(snap_we), 32'h0);
    check("lb_be", 32'(snap_be), 32'b1000);
    check("lb_addr", snap_addr, 32'h0000_1000);
    check("lb_stalls", 32'(stalls), 32'd4);
    check("lb_wdata", wdata_o, 32'hFFFF_FF80);
    check("lb_wd", 32'(wd_o), 32'd5);
    check("lb_wreg", 32'(wreg_o), 32'h1);
    check("lb_no_buserr", 32'(bus_err_o), 32'h0);
    check("lb_req_done", 32'(dbus_req), 32'h0);
    step();

    // 3: SH upper half, immediate ack
    drive(OP_SH, 32'h0000_2002, 32'hABCD_5678, 5'd0, 1'b0, 32'h0);
    run_mem(1, 32'h0);
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0);
    check("sh_we", 32'(snap_we), 32'h1);
    check("sh_be", 32'(snap_be), 32'b1100);
    check("sh_wdata", snap_wdata, 32'h5678_5678);
    check("sh_addr", snap_addr, 32'h0000_2000);
    check("sh_stalls", 32'(stalls), 32'd1);
    check("sh_latency", 32'(cycles), 32'd2);
    check("sh_wdata_o", wdata_o, 32'h0);
    step();

    // 4: misaligned LW
    drive(OP_LW, 32'h0000_3001, 32'h0, 5'd7, 1'b1, 32'h0);
    @(negedge clk);
    check("mis_stall", 32'(stallreq), 32'h0);
    step();
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    check("mis_addr_err", 32'(addr_err_o), 32'h1);
    check("mis_bad_addr", bad_addr_o, 32'h0000_3001);
    check("mis_wreg", 32'(wreg_o), 32'h0);
    check("mis_req", 32'(dbus_req), 32'h0);
    step();
    check("mis_pulse_end", 32'(addr_err_o), 32'h0);

    // 5: LW that never gets an ack
    drive(OP_LW, 32'h0000_4000, 32'h0, 5'd9, 1'b1, 32'h0);
    run_mem(0, 32'h0);
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    check("to_stalls", 32'(stalls), 32'd4);
    check("to_cycles", 32'(cycles), 32'd5);
    check("to_bus_err", 32'(bus_err_o), 32'h1);
    check("to_req", 32'(dbus_req), 32'h0);
    check("to_wreg", 32'(wreg_o), 32'h0);
    check("to_bad_addr", bad_addr_o, 32'h0000_4000);
    step();
    check("to_pulse_end", 32'(bus_err_o), 32'h0);

    // 6: async reset in the middle of an SW, then an LH completes
    drive(OP_SW, 32'h0000_5004, 32'h1111_2222, 5'd0, 1'b0, 32'h0);
    step();
    step();
    check("sw_req_busy", 32'(dbus_req), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(dbus_req), 32'h0);
    check("rst_mid_bad", bad_addr_o, 32'h0);
    check("rst_mid_be", 32'(dbus_be), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    step();
    drive(OP_LH, 32'h0000_0010, 32'h0, 5'd12, 1'b1, 32'h0);
    run_mem(2, 32'h1234_8001);
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    check("lh_be", 32'(snap_be), 32'b0011);
    check("lh_stalls", 32'(stalls), 32'd2);
    check("lh_wdata", wdata_o, 32'hFFFF_8001);
    check("lh_wd", 32'(wd_o), 32'd12);
    check("lh_wreg", 32'(wreg_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
